// File: rtl/psum_drain.sv
// Drains a PE's partial sums: requests the stream, rounds/saturates each 48-bit psum
// to a 16-bit word and forwards it through a small show-ahead FIFO on a valid/ready port.
module psum_drain #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned PSUM_DATA_WIDTH = 48,
    parameter int unsigned PARA_WIDTH      = 8,
    parameter int unsigned FRAC_SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PARA_WIDTH-1:0]      num_psum,
    input  logic                       psum_acc_finish,
    output logic                       psum_out_start,
    input  logic                       psum_out_valid,
    input  logic [PSUM_DATA_WIDTH-1:0] psum_to_bus,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       drain_busy,
    output logic                       drain_done,
    output logic                       sat_flag,
    output logic                       err_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = PSUM_DATA_WIDTH + 1;
    localparam logic signed [TW-1:0] RND     = TW'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [TW-1:0] SAT_MAX = TW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, START, COLLECT, FLUSH} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                 state;
    logic [PARA_WIDTH-1:0]  n_lat;
    logic [PARA_WIDTH-1:0]  cnt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            fcnt;
    entry_t                 mem [FIFO_DEPTH];

    logic signed [TW-1:0]   cv_sum;
    logic signed [TW-1:0]   cv_shift;
    logic                   cv_hi;
    logic                   cv_lo;
    logic [DATA_WIDTH-1:0]  cv_word;

    logic                   collecting;
    logic                   push_req;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   is_last;
    entry_t                 new_e;
    entry_t                 head_nxt;
    logic [AW-1:0]          rd_nxt;
    logic [AW:0]            fcnt_nxt;

    // Round half up at one extra bit so the bias add never wraps, then clamp.
    always_comb begin
        cv_sum   = $signed({psum_to_bus[PSUM_DATA_WIDTH-1], psum_to_bus}) + RND;
        cv_shift = cv_sum >>> FRAC_SHIFT;
        cv_hi    = cv_shift > SAT_MAX;
        cv_lo    = cv_shift < SAT_MIN;
        if (cv_hi) begin
            cv_word = DATA_WIDTH'(SAT_MAX);
        end else if (cv_lo) begin
            cv_word = DATA_WIDTH'(SAT_MIN);
        end else begin
            cv_word = DATA_WIDTH'(cv_shift);
        end
    end

    // FIFO control; a full FIFO still accepts when the head leaves the same cycle.
    always_comb begin
        collecting = (state == START) || (state == COLLECT);
        push_req   = collecting && psum_out_valid;
        pop        = out_valid && out_ready;
        full       = (fcnt == (AW+1)'(FIFO_DEPTH));
        push_ok    = push_req && (!full || pop);
        is_last    = (({1'b0, cnt} + (PARA_WIDTH+1)'(1)) == {1'b0, n_lat});
        new_e      = {is_last, cv_word};
        rd_nxt     = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        case ({push_ok, pop})
            2'b10:   fcnt_nxt = fcnt + (AW+1)'(1);
            2'b01:   fcnt_nxt = fcnt - (AW+1)'(1);
            default: fcnt_nxt = fcnt;
        endcase
        // The next head is the word being written when it lands on the read slot.
        if (push_ok && (wr_ptr == rd_nxt)) begin
            head_nxt = new_e;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            n_lat          <= '0;
            cnt            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fcnt           <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            psum_out_start <= 1'b0;
            drain_busy     <= 1'b0;
            drain_done     <= 1'b0;
            sat_flag       <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            psum_out_start <= 1'b0;
            drain_done     <= 1'b0;

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_nxt;
            fcnt      <= fcnt_nxt;
            out_valid <= (fcnt_nxt != '0);
            if (fcnt_nxt != '0) begin
                out_data <= head_nxt.data;
                out_last <= head_nxt.last;
            end else begin
                out_last <= 1'b0;
            end

            if ((push_req && !push_ok) || (psum_out_valid && !collecting)) begin
                err_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    drain_busy <= 1'b0;
                    if (psum_acc_finish) begin
                        n_lat      <= num_psum;
                        cnt        <= '0;
                        sat_flag   <= 1'b0;
                        drain_busy <= 1'b1;
                        if (num_psum != '0) begin
                            state          <= START;
                            psum_out_start <= 1'b1;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end
                START, COLLECT: begin
                    if (push_req) begin
                        cnt <= cnt + PARA_WIDTH'(1);
                        if (cv_hi || cv_lo) begin
                            sat_flag <= 1'b1;
                        end
                    end
                    if (push_req && is_last) begin
                        state <= FLUSH;
                    end else begin
                        state <= COLLECT;
                    end
                end
                FLUSH: begin
                    // drain_busy stays high through the drain_done cycle.
                    if (fcnt == '0) begin
                        drain_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: stimulus queues expected output words, a negedge
// monitor checks every accepted transfer; control/timing events are checked inline.
module tb_psum_drain;

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 48;
    localparam int unsigned NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] num_psum;
    logic          psum_acc_finish;
    logic          psum_out_start;
    logic          psum_out_valid;
    logic [PW-1:0] psum_to_bus;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          drain_busy;
    logic          drain_done;
    logic          sat_flag;
    logic          err_overflow;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   c;

    always #5 clk = ~clk;

    psum_drain dut (
        .clk            (clk),
        .rst            (rst),
        .num_psum       (num_psum),
        .psum_acc_finish(psum_acc_finish),
        .psum_out_start (psum_out_start),
        .psum_out_valid (psum_out_valid),
        .psum_to_bus    (psum_to_bus),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .drain_busy     (drain_busy),
        .drain_done     (drain_done),
        .sat_flag       (sat_flag),
        .err_overflow   (err_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted transfer must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_drain(input logic [NW-1:0] n);
        num_psum        = n;
        psum_acc_finish = 1'b1;
        step();
        psum_acc_finish = 1'b0;
    endtask

    task automatic send(input logic [PW-1:0] v, input logic [DW-1:0] d, input logic l,
                        input logic expect_push);
        psum_out_valid = 1'b1;
        psum_to_bus    = v;
        if (expect_push) exp_q.push_back({l, d});
        step();
        psum_out_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            @(negedge clk);
            if (drain_done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        rst             = 1'b1;
        psum_out_valid  = 1'b0;
        psum_acc_finish = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst             = 1'b1;
        num_psum        = '0;
        psum_acc_finish = 1'b0;
        psum_out_valid  = 1'b0;
        psum_to_bus     = '0;
        out_ready       = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_start", 64'(psum_out_start), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(drain_busy), 64'd0);
        check("rst_done", 64'(drain_done), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Basic drain N=3
        start_drain(8'd3);
        @(negedge clk);
        check("t1_start", 64'(psum_out_start), 64'd1);
        check("t1_busy", 64'(drain_busy), 64'd1);
        step();
        @(negedge clk);
        check("t1_start_pulse", 64'(psum_out_start), 64'd0);
        send(48'h100, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        check("t1_latency_data", 64'(out_data), 64'd1);
        send(48'h180, 16'd2, 1'b0, 1'b1);
        send(48'h27F, 16'd2, 1'b1, 1'b1);
        wait_done(c);
        check("t1_done_lat", 64'(c), 64'd2);
        check("t1_busy_at_done", 64'(drain_busy), 64'd1);
        check("t1_sat", 64'(sat_flag), 64'd0);
        check("t1_err", 64'(err_overflow), 64'd0);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        step();
        @(negedge clk);
        check("t1_busy_after", 64'(drain_busy), 64'd0);

        // Saturation and rounding, first word in the START cycle
        start_drain(8'd4);
        @(negedge clk);
        check("t2_sat_cleared", 64'(sat_flag), 64'd0);
        send(48'h0000_7FFF_FF00, 16'h7FFF, 1'b0, 1'b1);
        send(-48'sh7FFFFF00, 16'h8000, 1'b0, 1'b1);
        send(48'hFFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b1);
        send(-48'sh180, 16'hFFFF, 1'b1, 1'b1);
        wait_done(c);
        check("t2_done_lat", 64'(c), 64'd2);
        check("t2_sat", 64'(sat_flag), 64'd1);
        check("t2_err", 64'(err_overflow), 64'd0);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure N=6: words 5 and 6 dropped
        out_ready = 1'b0;
        start_drain(8'd6);
        step();
        for (int k = 1; k <= 6; k++) begin
            send(PW'(k * 256), DW'(k), (k == 6), (k <= 4));
        end
        @(negedge clk);
        check("t3_err", 64'(err_overflow), 64'd1);
        check("t3_busy", 64'(drain_busy), 64'd1);
        check("t3_no_done", 64'(drain_done), 64'd0);
        check("t3_head_valid", 64'(out_valid), 64'd1);
        check("t3_head_data", 64'(out_data), 64'd1);
        step();
        out_ready = 1'b1;
        wait_done(c);
        check("t3_done_lat", 64'(c), 64'd5);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Concurrent push/pop at full, N=8
        reset_dut();
        out_ready = 1'b0;
        start_drain(8'd8);
        step();
        for (int k = 1; k <= 4; k++) send(PW'(k * 256), DW'(k), 1'b0, 1'b1);
        out_ready = 1'b1;
        for (int k = 5; k <= 8; k++) send(PW'(k * 256), DW'(k), (k == 8), 1'b1);
        wait_done(c);
        check("t4_done_lat", 64'(c), 64'd5);
        check("t4_err", 64'(err_overflow), 64'd0);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // N=0
        step();
        start_drain(8'd0);
        @(negedge clk);
        check("t5_no_start", 64'(psum_out_start), 64'd0);
        check("t5_busy", 64'(drain_busy), 64'd1);
        check("t5_no_early_done", 64'(drain_done), 64'd0);
        step();
        @(negedge clk);
        check("t5_done", 64'(drain_done), 64'd1);
        step();
        @(negedge clk);
        check("t5_busy_after", 64'(drain_busy), 64'd0);
        check("t5_err", 64'(err_overflow), 64'd0);

        // Stray word in IDLE
        send(48'h500, 16'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_stray_err", 64'(err_overflow), 64'd1);
        check("t6_stray_no_valid", 64'(out_valid), 64'd0);

        // Second psum_acc_finish during COLLECT is ignored
        reset_dut();
        start_drain(8'd3);
        step();
        send(48'h100, 16'd1, 1'b0, 1'b1);
        num_psum        = 8'd1;
        psum_acc_finish = 1'b1;
        send(48'h200, 16'd2, 1'b0, 1'b1);
        psum_acc_finish = 1'b0;
        @(negedge clk);
        check("t7_no_restart", 64'(psum_out_start), 64'd0);
        send(48'h300, 16'd3, 1'b1, 1'b1);
        wait_done(c);
        check("t7_done_lat", 64'(c), 64'd2);
        check("t7_err", 64'(err_overflow), 64'd0);
        check("t7_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-COLLECT after 2 of 5 words
        out_ready = 1'b0;
        start_drain(8'd5);
        step();
        send(48'h100, 16'd1, 1'b0, 1'b1);
        send(48'h200, 16'd2, 1'b0, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t8_valid", 64'(out_valid), 64'd0);
        check("t8_data", 64'(out_data), 64'd0);
        check("t8_busy", 64'(drain_busy), 64'd0);
        check("t8_done", 64'(drain_done), 64'd0);
        check("t8_start", 64'(psum_out_start), 64'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        start_drain(8'd2);
        step();
        send(48'h100, 16'd1, 1'b0, 1'b1);
        send(48'h1FF, 16'd2, 1'b1, 1'b1);
        wait_done(c);
        check("t8_done_lat", 64'(c), 64'd2);
        check("t8_err", 64'(err_overflow), 64'd0);
        check("t8_q_empty", 64'(exp_q.size()), 64'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
# psum_drain

Bus-side drain for a PE's partial-sum output port. When the PE reports accumulation complete (`psum_acc_finish`), the block pulses `psum_out_start` and captures the expected number of 48-bit psums from `psum_to_bus`/`psum_out_valid`. It rounds and saturates each psum to a 16-bit fixed-point word, buffers it in a small FIFO, and presents it to the global buffer over a valid/ready stream. It is the receiving end of the PE output path and the counterpart of the feature/weight feeders on the PE input side.

## Interface
- DATA_WIDTH, 16, output word width, signed.
- PSUM_DATA_WIDTH, 48, PE psum width, signed.
- PARA_WIDTH, 8, width of the count parameter.
- FRAC_SHIFT, 8, right-shift applied in conversion; must be ≥1.
- FIFO_DEPTH, 4, output FIFO entries; power of two.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- num_psum  in  PARA_WIDTH  psums expected per drain; sampled on an accepted `psum_acc_finish`.
- psum_acc_finish  in  1  one-cycle pulse from the PE: psums are ready to stream.
- psum_out_start  out  1  one-cycle pulse to the PE requesting the psum stream.
- psum_out_valid  in  1  PE word strobe; no backpressure toward the PE.
- psum_to_bus  in  PSUM_DATA_WIDTH  PE psum word.
- out_data  out  DATA_WIDTH  converted word at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts; a transfer occurs when `out_valid & out_ready`.
- out_last  out  1  high with the word that is the Nth of the current drain.
- drain_busy  out  1  state ≠ IDLE.
- drain_done  out  1  one-cycle pulse at drain completion.
- sat_flag  out  1  sticky: at least one word saturated in the current drain.
- err_overflow  out  1  sticky: a word was dropped (FIFO full or unexpected word); cleared only by `rst`.

## Operation
- States: IDLE, START, COLLECT, FLUSH.
- IDLE:
  - On `psum_acc_finish`: latch N = `num_psum`, clear count and `sat_flag`.
  - If N≠0, go to START. If N=0, go to FLUSH; no `psum_out_start` is issued.
- START: assert `psum_out_start` for exactly this cycle, then go to COLLECT.
  - `psum_out_valid` is also accepted in this cycle; the PE may respond with zero latency.
- COLLECT: each cycle with `psum_out_valid`:
  - Convert the word and push it to the FIFO; count++.
  - The pushed entry carries a last tag equal to (count+1 == N).
  - When the Nth word is pushed, go to FLUSH.
- FLUSH: when the FIFO is empty, pulse `drain_done` and return to IDLE.
- Conversion:
  - Compute `t = psum + 2^(FRAC_SHIFT-1)` at PSUM_DATA_WIDTH+1 bits, so the add cannot wrap.
  - Arithmetic shift right by FRAC_SHIFT.
  - Saturate to [-32768, 32767]; any clamp sets `sat_flag`.
- FIFO full on push:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the word is dropped, `err_overflow` is set, and count still increments so the drain terminates.
- Unexpected words: `psum_out_valid` in IDLE or FLUSH is ignored and sets `err_overflow`.
- `psum_acc_finish` outside IDLE is ignored and does not set an error.
- `out_last` is the last tag of the head entry, qualified by `out_valid`.

## Timing
- Reset values: `psum_out_start` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `drain_busy` 0, `drain_done` 0, `sat_flag` 0, `err_overflow` 0; state IDLE, FIFO empty, count 0.
- Reset mid-drain aborts immediately, flushes the FIFO, and produces no `drain_done`.
- `psum_out_start` is high in cycle T+1 when `psum_acc_finish` is high in cycle T.
- Word latency: a word with `psum_out_valid` at cycle C appears on `out_data`/`out_valid` from cycle C+1; registered FIFO with show-ahead head.
- Throughput: one word per cycle in and out. A full FIFO with `out_ready`=1 sustains back-to-back pushes.
- `drain_done` is in the cycle after the FIFO empties in FLUSH, and at the earliest 2 cycles after the last pop.
- For N=0, `drain_done` is at T+2.
- `drain_busy` is high from T+1 through the `drain_done` cycle.

## Test plan
- Basic drain, N=3, `out_ready`=1:
  - Stimulus: `psum_acc_finish` @T; PE sends 0x100, 0x180, 0x27F at T+2..T+4.
  - Response: `psum_out_start` @T+1; `out_data` = 1, 2, 2 at T+3..T+5; `out_last` only on the third word; `drain_done` pulse; `sat_flag`=0.
- Saturation and rounding:
  - 0x7FFFFF00 → 32767, `sat_flag`=1.
  - −0x7FFFFF00 → −32768.
  - −1 → 0.
  - −0x180 → −1 (round half up).
- Backpressure, N=6, FIFO_DEPTH=4:
  - Stimulus: `out_ready`=0 during the burst.
  - Response: words 5 and 6 dropped, `err_overflow`=1, count reaches 6, FLUSH entered; after `out_ready`=1, 4 words pop and `drain_done` fires.
- Concurrent push/pop at full:
  - Stimulus: FIFO full with `out_ready`=1, continuous `psum_out_valid`.
  - Response: no drops, `err_overflow` stays 0, output order preserved.
- Edge events:
  - N=0: `drain_done` at T+2, no `psum_out_start`.
  - Stray `psum_out_valid` in IDLE: sets `err_overflow`.
  - Second `psum_acc_finish` during COLLECT: ignored.
- Reset mid-COLLECT after 2 of 5 words:
  - Response: all outputs at reset values next cycle; a following drain with N=2 completes normally.
